ddr3_req_arb: RTL and testbench
===============================

DDR3_REQ_ARB -- requirements
Module: ddr3_req_arb

Interface
REQ-001 SHALL provide parameter NUM_REQ, default 4, number of CPU-side requesters (2..8).
REQ-002 SHALL provide parameter ADDR_W, default 27, request address width.
REQ-003 SHALL provide parameter WDOG_CYC, default 1024, watchdog limit in cpu_clk cycles.
REQ-004 SHALL have port cpu_clk  input  1  the single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port req  input  NUM_REQ  per-requester request, level, held until gnt.
REQ-007 SHALL have port req_cmd  input  NUM_REQ  per-requester command; 1 = write, 0 = read.
REQ-008 SHALL have port req_addr  input  NUM_REQ*ADDR_W  packed addresses; requester i in slice [i*ADDR_W +: ADDR_W].
REQ-009 SHALL have port gnt  output  NUM_REQ  one-cycle grant pulse to the selected requester.
REQ-010 SHALL have port done  output  NUM_REQ  one-cycle completion pulse to the owning requester.
REQ-011 SHALL have port cont_valid  output  1  address-valid to the memory controller.
REQ-012 SHALL have port cont_cmd  output  1  latched command to the controller.
REQ-013 SHALL have port cont_addr  output  ADDR_W  latched address to the controller.
REQ-014 SHALL have port cont_busy  input  1  controller accepted request / transaction in progress.
REQ-015 SHALL have port cont_done  input  1  one-cycle controller completion pulse.
REQ-016 SHALL have port owner  output  $clog2(NUM_REQ)  index of current or last owner.
REQ-017 SHALL have port wdog_err  output  1  sticky watchdog error flag.

Function
REQ-018 SHALL implement FSM IDLE, ISSUE, WAIT; one transaction in flight maximum.
REQ-019 IDLE: when any req bit set, SHALL select round-robin starting at (last_owner+1) mod NUM_REQ, latch req_cmd/req_addr of winner into cont_cmd/cont_addr, set owner, go ISSUE next cycle.
REQ-020 Latency: req sampled high in IDLE at cycle t SHALL give cont_valid=1 and gnt[owner]=1 at cycle t+1.
REQ-021 gnt SHALL be high exactly one cycle per transaction (first ISSUE cycle); at most one gnt/done bit set at any time.
REQ-022 ISSUE: cont_valid SHALL stay 1 with stable cont_cmd/cont_addr until cont_busy=1 sampled; then cont_valid=0 and go WAIT.
REQ-023 WAIT: on cont_done=1, SHALL pulse done[owner] next cycle and return IDLE; last_owner=owner.
REQ-024 cont_busy and cont_done high together in ISSUE SHALL be treated as complete: done pulse, return IDLE, skip WAIT.
REQ-025 Back-to-back: cont_done at cycle d SHALL allow next cont_valid no earlier than d+2.
REQ-026 Requester dropping req before selection SHALL not be granted; dropping req after latch SHALL not abort the transaction.
REQ-027 Inputs cont_busy/cont_done in IDLE SHALL be ignored.
REQ-028 Requests arriving in ISSUE/WAIT SHALL wait; no requester starved beyond NUM_REQ-1 intervening transactions.

Reset
REQ-029 reset SHALL force: state IDLE, gnt=0, done=0, cont_valid=0, cont_cmd=0, cont_addr=0, owner=0, last_owner=NUM_REQ-1 (requester 0 wins first), wdog_err=0, watchdog counter=0.
REQ-030 reset mid-transaction SHALL abandon it with no done pulse; first post-reset arbitration restarts at requester 0.

Configuration
REQ-031 With DDR3_ARB_WDOG_EN defined, SHALL count cycles in ISSUE+WAIT (clear on IDLE); reaching WDOG_CYC SHALL set wdog_err (sticky until reset), pulse done[owner], return IDLE.
REQ-032 Without DDR3_ARB_WDOG_EN, no counter SHALL exist, wdog_err SHALL be tied 0, FSM waits indefinitely.

Verification
REQ-033 Single request: req=4'b0100, write, addr=27'h0000ABC; cont_busy 2 cycles later, cont_done 5 later -> gnt=4'b0100 at t+1, cont_addr=27'h0000ABC, cont_cmd=1, done=4'b0100 once.
REQ-034 All four requesting continuously after reset -> grant order 0,1,2,3,0; each done matches owner.
REQ-035 cont_busy and cont_done same cycle in ISSUE -> done pulse next cycle, WAIT never entered, next cont_valid 2 cycles after done.
REQ-036 reset asserted in WAIT owner=2 -> all outputs reset values next cycle, no done[2], next grant to requester 0 when req=4'b1111.
REQ-037 DDR3_ARB_WDOG_EN, WDOG_CYC=16, cont_done never asserted -> wdog_err=1 and done[owner] after 16 cycles in ISSUE+WAIT; without macro, state stays WAIT, wdog_err=0.
REQ-038 req[1] pulsed one cycle during WAIT then dropped -> requester 1 never granted.

Source files
------------

// File: rtl/ddr3_req_arb.sv
// Round-robin arbiter funnelling NUM_REQ CPU requesters onto one DDR3 controller port; grant one cycle after request, one transaction in flight.
// Requesters hold req until gnt; cont_valid holds until cont_busy. Optional watchdog under `DDR3_ARB_WDOG_EN.
module ddr3_req_arb #(
  parameter int NUM_REQ  = 4,
  parameter int ADDR_W   = 27,
  parameter int WDOG_CYC = 1024
) (
  input  logic                       cpu_clk,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req,
  input  logic [NUM_REQ-1:0]         req_cmd,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [NUM_REQ-1:0]         done,
  output logic                       cont_valid,
  output logic                       cont_cmd,
  output logic [ADDR_W-1:0]          cont_addr,
  input  logic                       cont_busy,
  input  logic                       cont_done,
  output logic [$clog2(NUM_REQ)-1:0] owner,
  output logic                       wdog_err
);

  localparam int OW = $clog2(NUM_REQ);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t              r_state;
  logic [NUM_REQ-1:0]  r_gnt;
  logic [NUM_REQ-1:0]  r_done;
  logic                r_cont_valid;
  logic                r_cont_cmd;
  logic [ADDR_W-1:0]   r_cont_addr;
  logic [OW-1:0]       r_owner;
  logic [OW-1:0]       r_last_owner;

  state_t              w_state_nxt;
  logic [NUM_REQ-1:0]  w_gnt_nxt;
  logic [NUM_REQ-1:0]  w_done_nxt;
  logic                w_valid_nxt;
  logic                w_cmd_nxt;
  logic [ADDR_W-1:0]   w_addr_nxt;
  logic [OW-1:0]       w_owner_nxt;
  logic [OW-1:0]       w_last_nxt;

  logic                w_any;
  logic [OW-1:0]       w_win;
  logic [OW-1:0]       w_rr_idx;
  logic [ADDR_W-1:0]   w_win_addr;
  logic                w_norm_fin;
  logic                w_wdog_hit;
  logic                w_finish;

  // Scan from farthest to nearest so the requester just after last_owner wins.
  always_comb begin
    w_any    = 1'b0;
    w_win    = '0;
    w_rr_idx = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      w_rr_idx = OW'((int'(r_last_owner) + k) % NUM_REQ);
      if (req[w_rr_idx]) begin
        w_any = 1'b1;
        w_win = w_rr_idx;
      end
    end
  end

  always_comb begin
    w_win_addr = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (w_win == OW'(i)) w_win_addr = req_addr[i*ADDR_W +: ADDR_W];
    end
  end

  // Busy+done together while issuing is a completed transaction.
  assign w_norm_fin = ((r_state == S_ISSUE) && cont_busy && cont_done) ||
                      ((r_state == S_WAIT) && cont_done);
  assign w_finish   = (r_state != S_IDLE) && (w_norm_fin || w_wdog_hit);

  always_comb begin
    w_state_nxt = r_state;
    w_gnt_nxt   = '0;
    w_done_nxt  = '0;
    w_valid_nxt = r_cont_valid;
    w_cmd_nxt   = r_cont_cmd;
    w_addr_nxt  = r_cont_addr;
    w_owner_nxt = r_owner;
    w_last_nxt  = r_last_owner;
    case (r_state)
      S_IDLE: begin
        w_valid_nxt = 1'b0;
        if (w_any) begin
          w_state_nxt       = S_ISSUE;
          w_gnt_nxt[w_win]  = 1'b1;
          w_valid_nxt       = 1'b1;
          w_cmd_nxt         = req_cmd[w_win];
          w_addr_nxt        = w_win_addr;
          w_owner_nxt       = w_win;
        end
      end
      S_ISSUE: begin
        if (cont_busy) begin
          w_valid_nxt = 1'b0;
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        w_valid_nxt = 1'b0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_valid_nxt = 1'b0;
      end
    endcase
    if (w_finish) begin
      w_state_nxt         = S_IDLE;
      w_valid_nxt         = 1'b0;
      w_done_nxt[r_owner] = 1'b1;
      w_last_nxt          = r_owner;
    end
  end

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_gnt        <= '0;
      r_done       <= '0;
      r_cont_valid <= 1'b0;
      r_cont_cmd   <= 1'b0;
      r_cont_addr  <= '0;
      r_owner      <= '0;
      r_last_owner <= OW'(NUM_REQ - 1);
    end else begin
      r_state      <= w_state_nxt;
      r_gnt        <= w_gnt_nxt;
      r_done       <= w_done_nxt;
      r_cont_valid <= w_valid_nxt;
      r_cont_cmd   <= w_cmd_nxt;
      r_cont_addr  <= w_addr_nxt;
      r_owner      <= w_owner_nxt;
      r_last_owner <= w_last_nxt;
    end
  end

`ifdef DDR3_ARB_WDOG_EN
  localparam int CW = $clog2(WDOG_CYC) + 1;

  logic [CW-1:0] r_wdog_cnt;
  logic          r_wdog_err;

  assign w_wdog_hit = (r_state != S_IDLE) && (r_wdog_cnt == CW'(WDOG_CYC - 1));

  always_ff @(posedge cpu_clk) begin
    if (reset) begin
      r_wdog_cnt <= '0;
      r_wdog_err <= 1'b0;
    end else begin
      if ((r_state == S_IDLE) || (w_state_nxt == S_IDLE)) r_wdog_cnt <= '0;
      else                                                r_wdog_cnt <= r_wdog_cnt + CW'(1);
      if (w_wdog_hit && !w_norm_fin) r_wdog_err <= 1'b1;
    end
  end

  assign wdog_err = r_wdog_err;
`else
  assign w_wdog_hit = 1'b0;
  assign wdog_err   = 1'b0;
`endif

  assign gnt        = r_gnt;
  assign done       = r_done;
  assign cont_valid = r_cont_valid;
  assign cont_cmd   = r_cont_cmd;
  assign cont_addr  = r_cont_addr;
  assign owner      = r_owner;

  a_cfg: assert property (@(posedge cpu_clk)
    (NUM_REQ >= 2) && (NUM_REQ <= 8) && (WDOG_CYC >= 1));
  a_gnt_onehot: assert property (@(posedge cpu_clk) disable iff (reset) $onehot0(gnt));
  a_done_onehot: assert property (@(posedge cpu_clk) disable iff (reset) $onehot0(done));
  a_gnt_with_valid: assert property (@(posedge cpu_clk) disable iff (reset)
    (gnt != '0) |-> cont_valid);

endmodule

// File: tb/tb_ddr3_req_arb.sv
// Randomized scoreboard bench for ddr3_req_arb against a transaction-level round-robin model.
module tb_ddr3_req_arb;

  localparam int NR = 4;
  localparam int AW = 27;

  logic              cpu_clk = 1'b0;
  logic              reset;
  logic [NR-1:0]     req;
  logic [NR-1:0]     req_cmd;
  logic [NR*AW-1:0]  req_addr;
  logic [NR-1:0]     gnt;
  logic [NR-1:0]     done;
  logic              cont_valid;
  logic              cont_cmd;
  logic [AW-1:0]     cont_addr;
  logic              cont_busy;
  logic              cont_done;
  logic [1:0]        owner;
  logic              wdog_err;

  ddr3_req_arb #(.NUM_REQ(NR), .ADDR_W(AW), .WDOG_CYC(16)) dut (
    .cpu_clk    (cpu_clk),
    .reset      (reset),
    .req        (req),
    .req_cmd    (req_cmd),
    .req_addr   (req_addr),
    .gnt        (gnt),
    .done       (done),
    .cont_valid (cont_valid),
    .cont_cmd   (cont_cmd),
    .cont_addr  (cont_addr),
    .cont_busy  (cont_busy),
    .cont_done  (cont_done),
    .owner      (owner),
    .wdog_err   (wdog_err)
  );

  always #5 cpu_clk = ~cpu_clk;

  typedef struct {
    int          idx;
    int          cyc;
    logic        cmd;
    logic [AW-1:0] addr;
  } exp_t;

  exp_t gq[$];
  exp_t dq[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [NR-1:0] pend;
  logic [NR-1:0] pcmd;
  logic [AW-1:0] paddr [NR];
  int            last_own;

  always @(posedge cpu_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", nm, cyc, act, exp);
    end
  endtask

  // Round-robin rule: first pending requester after the last owner.
  function automatic int rr(input int last, input logic [NR-1:0] p);
    for (int k = 1; k <= NR; k++) begin
      int i;
      i = (last + k) % NR;
      if (p[i]) return i;
    end
    return -1;
  endfunction

  task automatic tick();
    @(posedge cpu_clk);
    #1;
  endtask

  task automatic drive_req();
    req     = pend;
    req_cmd = pcmd;
    for (int i = 0; i < NR; i++) req_addr[i*AW +: AW] = paddr[i];
  endtask

  task automatic add_req(input int i, input logic w, input logic [AW-1:0] a);
    pend[i]  = 1'b1;
    pcmd[i]  = w;
    paddr[i] = a;
  endtask

  task automatic add_rand(input int i);
    add_req(i, 1'($urandom), AW'($urandom));
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_gnt"},   64'(gnt), 0);
    chk({tag, "_done"},  64'(done), 0);
    chk({tag, "_valid"}, 64'(cont_valid), 0);
    chk({tag, "_cmd"},   64'(cont_cmd), 0);
    chk({tag, "_addr"},  64'(cont_addr), 0);
    chk({tag, "_owner"}, 64'(owner), 0);
    chk({tag, "_wdog"},  64'(wdog_err), 0);
  endtask

  task automatic idle_noise(input int n);
    for (int k = 0; k < n; k++) begin
      cont_busy = 1'($urandom);
      cont_done = 1'($urandom);
      tick();
    end
    cont_busy = 1'b0;
    cont_done = 1'b0;
  endtask

  // Called while the arbiter is idle with at least one pending request.
  task automatic txn(input int bdly, input int ddly, input bit same, input int pj,
                     input bit readd, input bit grow);
    exp_t e;
    exp_t d;
    int   w;
    w = rr(last_own, pend);
    drive_req();
    e.idx = w; e.cyc = cyc + 1; e.cmd = pcmd[w]; e.addr = paddr[w];
    gq.push_back(e);
    tick();
    if (!readd) pend[w] = 1'b0;
    if (grow) begin
      for (int i = 0; i < NR; i++) if (!pend[i] && ($urandom % 3 == 0)) add_rand(i);
    end
    drive_req();
    for (int k = 0; k < bdly; k++) begin
      chk("issue_valid", 64'(cont_valid), 1);
      chk("issue_addr", 64'(cont_addr), 64'(e.addr));
      tick();
    end
    cont_busy = 1'b1;
    d.idx = w; d.cmd = 1'b0; d.addr = '0;
    if (same) begin
      cont_done = 1'b1;
      d.cyc = cyc + 1;
      dq.push_back(d);
      tick();
    end else begin
      tick();
      chk("wait_valid", 64'(cont_valid), 0);
      if (pj >= 0 && !pend[pj]) begin
        pend[pj] = 1'b1;
        drive_req();
        tick();
        pend[pj] = 1'b0;
        drive_req();
      end
      repeat (ddly) tick();
      cont_done = 1'b1;
      d.cyc = cyc + 1;
      dq.push_back(d);
      tick();
    end
    cont_done = 1'b0;
    cont_busy = 1'b0;
    last_own  = w;
  endtask

  always @(negedge cpu_clk) begin
    if (!reset) begin
      if (gnt != '0) begin
        if (gq.size() == 0) chk("gnt_unexpected", 64'(gnt), 0);
        else begin
          exp_t e;
          e = gq.pop_front();
          chk("gnt_vec", 64'(gnt), 64'(1) << e.idx);
          chk("gnt_cycle", 64'(cyc), 64'(e.cyc));
          chk("gnt_valid", 64'(cont_valid), 1);
          chk("gnt_cmd", 64'(cont_cmd), 64'(e.cmd));
          chk("gnt_addr", 64'(cont_addr), 64'(e.addr));
          chk("gnt_owner", 64'(owner), 64'(e.idx));
          chk("gnt_wdog", 64'(wdog_err), 0);
        end
      end
      if (done != '0) begin
        if (dq.size() == 0) chk("done_unexpected", 64'(done), 0);
        else begin
          exp_t d;
          d = dq.pop_front();
          chk("done_vec", 64'(done), 64'(1) << d.idx);
          chk("done_cycle", 64'(cyc), 64'(d.cyc));
        end
      end
    end
  end

  initial begin
    exp_t e;
    exp_t d;
    int   w;
    int   g;
    reset = 1'b1; req = '0; req_cmd = '0; req_addr = '0;
    cont_busy = 1'b0; cont_done = 1'b0;
    pend = '0; pcmd = '0; last_own = NR - 1;
    for (int i = 0; i < NR; i++) paddr[i] = '0;
    repeat (3) tick();
    check_reset_vals("por");
    reset = 1'b0;

    // Everyone requesting continuously: 0,1,2,3,0.
    for (int i = 0; i < NR; i++) add_rand(i);
    for (int n = 0; n < 5; n++) txn(1, 2, 1'b0, -1, 1'b1, 1'b0);
    pend = '0;
    drive_req();
    idle_noise(2);

    // Single write from requester 2.
    add_req(2, 1'b1, 27'h0000ABC);
    txn(2, 4, 1'b0, -1, 1'b0, 1'b0);

    // Busy and done together, then a back-to-back request.
    add_rand(1);
    txn(1, 0, 1'b1, -1, 1'b0, 1'b0);
    add_rand(3);
    txn(0, 1, 1'b0, -1, 1'b0, 1'b0);

    // Requester 1 pulses during WAIT only; it must never be granted.
    add_rand(3);
    txn(0, 3, 1'b0, 1, 1'b0, 1'b0);
    idle_noise(4);

    for (int n = 0; n < 60; n++) begin
      if (pend == '0) begin
        idle_noise(int'($urandom % 3));
        add_rand(int'($urandom % NR));
        for (int i = 0; i < NR; i++) if ($urandom % 3 == 0) add_rand(i);
      end
      txn(int'($urandom % 4), int'($urandom % 5), ($urandom % 4) == 0,
          (($urandom % 3) == 0) ? int'($urandom % NR) : -1, 1'b0, 1'($urandom));
    end
    while (pend != '0) txn(1, 1, 1'b0, -1, 1'b0, 1'b0);
    drive_req();

    // Reset while requester 2 is in WAIT.
    add_rand(2);
    w = rr(last_own, pend);
    drive_req();
    e.idx = w; e.cyc = cyc + 1; e.cmd = pcmd[w]; e.addr = paddr[w];
    gq.push_back(e);
    tick();
    pend[w] = 1'b0;
    drive_req();
    cont_busy = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    for (int i = 0; i < NR; i++) add_rand(i);
    drive_req();
    cont_busy = 1'b0;
    tick();
    check_reset_vals("rst_wait");
    reset = 1'b0;
    last_own = NR - 1;
    while (pend != '0) txn(1, 1, 1'b0, -1, 1'b0, 1'b0);
    drive_req();

    // Controller never completes.
    add_rand(int'($urandom % NR));
    w = rr(last_own, pend);
    drive_req();
    e.idx = w; e.cyc = cyc + 1; e.cmd = pcmd[w]; e.addr = paddr[w];
    gq.push_back(e);
    tick();
    g = cyc;
    pend[w] = 1'b0;
    drive_req();
    cont_busy = 1'b1;
`ifdef DDR3_ARB_WDOG_EN
    d.idx = w; d.cyc = g + 16; d.cmd = 1'b0; d.addr = '0;
    dq.push_back(d);
    while (cyc < g + 16) tick();
    chk("wdog_set", 64'(wdog_err), 1);
    cont_busy = 1'b0;
    last_own = w;
    repeat (3) tick();
    chk("wdog_sticky", 64'(wdog_err), 1);
`else
    repeat (40) tick();
    chk("hang_valid", 64'(cont_valid), 0);
    chk("hang_wdog", 64'(wdog_err), 0);
    chk("hang_owner", 64'(owner), 64'(w));
    cont_busy = 1'b0;
    reset = 1'b1;
    tick();
    reset = 1'b0;
    last_own = NR - 1;
`endif
    repeat (3) tick();
    chk("gq_empty", 64'(gq.size()), 0);
    chk("dq_empty", 64'(dq.size()), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
